// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bundle: redirect/stall inputs, imem handshake, IF/ID outputs.
// The master modport is the controller's view; slave is the environment's view.
interface pc_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] PC_out;
    logic [XLEN-1:0] PC_plus4;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            misalign_err;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_ready,
        output imem_req, imem_addr, PC_out, PC_plus4,
        output fetch_valid, fetch_pc, misalign_err
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_ready,
        input  imem_req, imem_addr, PC_out, PC_plus4,
        input  fetch_valid, fetch_pc, misalign_err
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request sequencer with stall, redirect and
// sticky misaligned-target detection.
module pc_fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input logic           clk,
    input logic           reset,
    pc_fetch_ctrl_if.master bus
);
    localparam int OFF = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fv;
    logic [XLEN-1:0] r_fpc;
    logic            r_err;
    logic [XLEN-1:0] w_pc_next;
    logic            w_aligned;

    assign w_pc_next = r_pc + XLEN'(INSTR_BYTES);
    assign w_aligned = (bus.redirect_target[OFF-1:0] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_fv    <= 1'b0;
            r_fpc   <= '0;
            r_err   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect wins in every state; any same-cycle response is dropped.
            r_fv <= 1'b0;
            if (w_aligned) begin
                r_pc    <= bus.redirect_target;
                r_state <= RUN;
            end else begin
                r_err   <= 1'b1;
                r_state <= ERROR;
            end
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_fv    <= 1'b0;
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (bus.imem_ready) begin
                            r_pc  <= w_pc_next;
                            r_fpc <= r_pc;
                            r_fv  <= 1'b1;
                        end else begin
                            r_fv <= 1'b0;
                        end
                    end
                end
                ERROR: begin
                    r_fv <= 1'b0;
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign bus.imem_req     = (r_state == RUN);
    assign bus.imem_addr    = r_pc;
    assign bus.PC_out       = r_pc;
    assign bus.PC_plus4     = w_pc_next;
    assign bus.fetch_valid  = r_fv;
    assign bus.fetch_pc     = r_fpc;
    assign bus.misalign_err = r_err;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Vector table, randomized reference-model run, and wrap-vector corner cases
// for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic wrst;

    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.XLEN(32)) b ();
    pc_fetch_ctrl_if #(.XLEN(32)) w ();

    pc_fetch_ctrl #(
        .XLEN(32), .RESET_VECTOR(32'h0000_0000), .INSTR_BYTES(4)
    ) u_dut (
        .clk(clk), .reset(rst), .bus(b.master)
    );

    pc_fetch_ctrl #(
        .XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .INSTR_BYTES(4)
    ) u_wrap (
        .clk(clk), .reset(wrst), .bus(w.master)
    );

    typedef struct {
        bit          rs;
        bit          st;
        bit          rv;
        logic [31:0] tg;
        bit          rdy;
        logic [31:0] pc;
        bit          req;
        bit          fv;
        logic [31:0] fpc;
        bit          err;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc,
                           input bit req, input bit fv,
                           input logic [31:0] fpc, input bit err);
        chk({tag, " pc"}, b.PC_out, pc);
        chk({tag, " addr"}, b.imem_addr, pc);
        chk({tag, " plus4"}, b.PC_plus4, pc + 32'd4);
        chk({tag, " req"}, {31'd0, b.imem_req}, {31'd0, req});
        chk({tag, " fv"}, {31'd0, b.fetch_valid}, {31'd0, fv});
        chk({tag, " fpc"}, b.fetch_pc, fpc);
        chk({tag, " err"}, {31'd0, b.misalign_err}, {31'd0, err});
    endtask

    // Reference state: transaction-level view of the controller
    logic [31:0] m_pc, m_fpc;
    bit          m_fv, m_err, m_boot, m_halt;

    task automatic model(input bit rs, input bit st, input bit rv,
                         input logic [31:0] tg, input bit rdy);
        if (rs) begin
            m_pc = 32'h0; m_boot = 1; m_halt = 0;
            m_fv = 0; m_fpc = 32'h0; m_err = 0;
        end else if (rv) begin
            m_fv = 0;
            m_boot = 0;
            if (tg % 4 == 0) begin
                m_pc = tg; m_halt = 0;
            end else begin
                m_err = 1; m_halt = 1;
            end
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_halt || st) begin
        end else if (rdy) begin
            m_fpc = m_pc; m_pc = m_pc + 4; m_fv = 1;
        end else begin
            m_fv = 0;
        end
    endtask

    vec_t tv[28];

    initial begin
        tv[0]  = '{1,0,0,32'h0,  1, 32'h0,  0,0,32'h0,  0};
        tv[1]  = '{1,0,0,32'h0,  1, 32'h0,  0,0,32'h0,  0};
        tv[2]  = '{0,0,0,32'h0,  1, 32'h0,  1,0,32'h0,  0};
        tv[3]  = '{0,0,0,32'h0,  1, 32'h4,  1,1,32'h0,  0};
        tv[4]  = '{0,0,0,32'h0,  1, 32'h8,  1,1,32'h4,  0};
        tv[5]  = '{0,0,0,32'h0,  0, 32'h8,  1,0,32'h4,  0};
        tv[6]  = '{0,0,0,32'h0,  0, 32'h8,  1,0,32'h4,  0};
        tv[7]  = '{0,0,0,32'h0,  0, 32'h8,  1,0,32'h4,  0};
        tv[8]  = '{0,0,0,32'h0,  1, 32'hC,  1,1,32'h8,  0};
        tv[9]  = '{0,0,0,32'h0,  1, 32'h10, 1,1,32'hC,  0};
        tv[10] = '{0,1,0,32'h0,  1, 32'h10, 1,1,32'hC,  0};
        tv[11] = '{0,1,0,32'h0,  1, 32'h10, 1,1,32'hC,  0};
        tv[12] = '{0,0,0,32'h0,  1, 32'h14, 1,1,32'h10, 0};
        tv[13] = '{0,1,1,32'h100,1, 32'h100,1,0,32'h10, 0};
        tv[14] = '{0,0,0,32'h0,  1, 32'h104,1,1,32'h100,0};
        tv[15] = '{0,0,0,32'h0,  1, 32'h108,1,1,32'h104,0};
        tv[16] = '{0,0,1,32'h102,1, 32'h108,0,0,32'h104,1};
        tv[17] = '{0,0,0,32'h0,  1, 32'h108,0,0,32'h104,1};
        tv[18] = '{0,0,1,32'h200,0, 32'h200,1,0,32'h104,1};
        tv[19] = '{0,0,0,32'h0,  1, 32'h204,1,1,32'h200,1};
        tv[20] = '{0,0,0,32'h0,  0, 32'h204,1,0,32'h200,1};
        tv[21] = '{1,0,0,32'h0,  0, 32'h0,  0,0,32'h0,  0};
        tv[22] = '{0,0,1,32'h40, 1, 32'h40, 1,0,32'h0,  0};
        tv[23] = '{0,0,0,32'h0,  1, 32'h44, 1,1,32'h40, 0};
        tv[24] = '{1,0,0,32'h0,  1, 32'h0,  0,0,32'h0,  0};
        tv[25] = '{0,0,1,32'h3,  1, 32'h0,  0,0,32'h0,  1};
        tv[26] = '{1,0,0,32'h0,  1, 32'h0,  0,0,32'h0,  0};
        tv[27] = '{0,0,0,32'h0,  1, 32'h0,  1,0,32'h0,  0};

        rst = 1'b1;
        wrst = 1'b1;
        b.stall = 0; b.redirect_valid = 0;
        b.redirect_target = '0; b.imem_ready = 0;
        w.stall = 0; w.redirect_valid = 0;
        w.redirect_target = '0; w.imem_ready = 0;

        for (int i = 0; i < 28; i++) begin
            rst = tv[i].rs;
            b.stall = tv[i].st;
            b.redirect_valid = tv[i].rv;
            b.redirect_target = tv[i].tg;
            b.imem_ready = tv[i].rdy;
            edge1();
            chk_all($sformatf("vec%0d", i), tv[i].pc, tv[i].req,
                    tv[i].fv, tv[i].fpc, tv[i].err);
        end

        // Randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            bit          rs, st, rv, rdy;
            logic [31:0] tg;
            rs  = (i == 0) || ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            tg  = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            rdy = ($urandom_range(0, 2) != 0);
            rst = rs; b.stall = st; b.redirect_valid = rv;
            b.redirect_target = tg; b.imem_ready = rdy;
            model(rs, st, rv, tg, rdy);
            edge1();
            chk_all($sformatf("rnd%0d", i), m_pc, !m_boot && !m_halt,
                    m_fv, m_fpc, m_err);
        end
        rst = 1'b1;

        // Wrap at the top of the address space, then reset mid-wait
        chk("wrap rst pc", w.PC_out, 32'hFFFF_FFFC);
        chk("wrap plus4", w.PC_plus4, 32'h0);
        chk("wrap rst req", {31'd0, w.imem_req}, 32'd0);
        wrst = 1'b0; w.imem_ready = 1'b1;
        edge1();
        chk("wrap boot pc", w.PC_out, 32'hFFFF_FFFC);
        chk("wrap run req", {31'd0, w.imem_req}, 32'd1);
        edge1();
        chk("wrap pc", w.PC_out, 32'h0);
        chk("wrap fpc", w.fetch_pc, 32'hFFFF_FFFC);
        chk("wrap fv", {31'd0, w.fetch_valid}, 32'd1);
        chk("wrap err", {31'd0, w.misalign_err}, 32'd0);
        w.imem_ready = 1'b0;
        edge1();
        chk("wrap wait pc", w.PC_out, 32'h0);
        chk("wrap wait fv", {31'd0, w.fetch_valid}, 32'd0);
        wrst = 1'b1;
        edge1();
        chk("wrap midrst pc", w.PC_out, 32'hFFFF_FFFC);
        chk("wrap midrst fv", {31'd0, w.fetch_valid}, 32'd0);
        chk("wrap midrst fpc", w.fetch_pc, 32'h0);
        chk("wrap midrst req", {31'd0, w.imem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
